// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared widths and digit index type for the seven-segment scan controller
package seg_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;
    localparam int NIBBLE_W   = 4;

    typedef logic [DIGIT_W-1:0] digit_idx_t;
endpackage

// File: rtl/seg_scan_prescaler.sv
// rtl/seg_scan_prescaler.sv - scan-rate prescaler, one tick per SCAN_DIV enabled cycles
module seg_scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic ENABLE,
    output logic tick
);
    localparam int CNT_W = $clog2(SCAN_DIV + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = ENABLE & (count == LAST);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (ENABLE) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit scan controller with double-buffered value load
// Optional leading-zero blanking is built when SEG_LZB_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                ENABLE,
    input  logic                LOAD_VALID,
    output logic                LOAD_READY,
    input  logic [15:0]         LOAD_VALUE,
    input  logic [3:0]          LOAD_DOTS,
    output logic [DIGIT_W-1:0]  SEG_SELECT,
    output logic [NIBBLE_W-1:0] BIN,
    output logic                DOT,
    output logic                DIGIT_BLANK,
    output logic                FRAME_TICK
);
    logic       tick;
    digit_idx_t digit;
    digit_idx_t digit_nxt;
    logic [15:0] shadow_value;
    logic [15:0] active_value;
    logic [15:0] active_value_nxt;
    logic [3:0]  shadow_dots;
    logic [3:0]  active_dots;
    logic [3:0]  active_dots_nxt;
    logic        frame_end;
    logic        transfer;
    logic        commit;

    seg_scan_prescaler #(
        .SCAN_DIV (SCAN_DIV)
    ) u_prescaler (
        .CLK    (CLK),
        .RESETN (RESETN),
        .ENABLE (ENABLE),
        .tick   (tick)
    );

    assign SEG_SELECT = digit;

    // LOAD_READY doubles as the inverted pending flag, so the shadow is full when it is low.
    always_comb begin
        digit_nxt        = tick ? digit_idx_t'(digit + 1'b1) : digit;
        frame_end        = tick & (digit == digit_idx_t'(NUM_DIGITS - 1));
        transfer         = LOAD_VALID & LOAD_READY;
        commit           = ~LOAD_READY & (frame_end | ~ENABLE);
        active_value_nxt = commit ? shadow_value : active_value;
        active_dots_nxt  = commit ? shadow_dots  : active_dots;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            digit        <= '0;
            shadow_value <= '0;
            shadow_dots  <= '0;
            active_value <= '0;
            active_dots  <= '0;
            LOAD_READY   <= 1'b1;
            BIN          <= '0;
            DOT          <= 1'b0;
            FRAME_TICK   <= 1'b0;
        end else begin
            digit        <= digit_nxt;
            active_value <= active_value_nxt;
            active_dots  <= active_dots_nxt;
            if (transfer) begin
                shadow_value <= LOAD_VALUE;
                shadow_dots  <= LOAD_DOTS;
                LOAD_READY   <= 1'b0;
            end else if (commit) begin
                LOAD_READY   <= 1'b1;
            end
            BIN        <= active_value_nxt[{digit_nxt, 2'b00} +: NIBBLE_W];
            DOT        <= active_dots_nxt[digit_nxt];
            FRAME_TICK <= frame_end;
        end
    end

`ifdef SEG_LZB_EN
    // A digit is blank when it and every more significant nibble are zero and its dot is off.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            DIGIT_BLANK <= 1'b0;
        end else begin
            DIGIT_BLANK <= (digit_nxt != '0)
                         && ((active_value_nxt >> {digit_nxt, 2'b00}) == 16'h0000)
                         && !active_dots_nxt[digit_nxt];
        end
    end
`else
    assign DIGIT_BLANK = 1'b0;
`endif
endmodule
